imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
Owns the instruction-memory port and sequences the CPU through program load, run and halt. After reset it holds the core in stall and accepts a word stream from a loader (bench or debug link) into inst mem through a valid/ready handshake. It then hands the port to the s1 fetch path. It detects end-of-test (PC self-loop or misaligned fetch) and parks the core in HALT. It sits between cpu_top's fetch stage and the instruction memory.

Parameters:
ADDR_W, 10, word-address width of instruction memory (DEPTH = 2**ADDR_W words)
HALT_CYC, 8, consecutive cycles with unchanged PC that declare a self-loop halt (range 2..255)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader word valid
ld_ready  out  1  loader word accepted this cycle when ld_valid & ld_ready
ld_addr  in  32  loader word address (word index, not byte)
ld_data  in  32  loader instruction word
ld_last  in  1  marks final word of the program
soft_clr  in  1  one-cycle pulse; HALT -> IDLE
pc_current_s1  in  32  fetch PC (byte address)
mem_en  out  1  instruction memory enable
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  instruction memory word address
mem_wdata  out  32  instruction memory write data
cpu_stall  out  1  freezes PC and pipeline
halted  out  1  high in HALT
ld_err  out  1  sticky: out-of-range load address seen
fetch_err  out  1  sticky: misaligned fetch PC seen
load_count  out  ADDR_W+1  words written since last IDLE, saturating at DEPTH
state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3

Behaviour:
- Reset (async, any state): state=IDLE, cpu_stall=1, halted=0, ld_err=0, fetch_err=0, load_count=0, stall counter=0, PC history reg=0.
- ld_ready = 1 in IDLE and LOAD; 0 in RUN and HALT.
- Accept event = ld_valid & ld_ready.
- Write path is combinational in the accept cycle:
  - mem_we = accept & (ld_addr < DEPTH).
  - mem_addr = ld_addr[ADDR_W-1:0].
  - mem_wdata = ld_data.
  - mem_en = mem_we.
- Out-of-range accept: the word is consumed with no write; ld_err is set and stays set until reset.
- Each in-range accept increments load_count, saturating at DEPTH.
- IDLE -> LOAD on accept without ld_last. IDLE -> RUN directly on accept with ld_last (single-word program).
- LOAD -> RUN on an accept with ld_last, registered at the next edge. While ld_valid is low, LOAD holds indefinitely.
- cpu_stall = 1 in IDLE, LOAD and HALT; 0 only in RUN. The first RUN cycle fetches pc_current_s1.
- RUN port ownership:
  - mem_en = 1, mem_we = 0.
  - mem_addr = pc_current_s1[ADDR_W+1:2]. Upper PC bits beyond the memory wrap silently.
- Self-loop detect in RUN:
  - A counter increments while pc_current_s1 equals the previous-cycle PC, and clears otherwise.
  - On reaching HALT_CYC-1 with equal PC → HALT next edge.
  - A PC 0→4→0 loop does not trigger halt.
- Misaligned fetch in RUN (pc_current_s1[1:0] != 0): fetch_err set (sticky), HALT next edge.
- If self-loop and misaligned fetch coincide, both flags act and HALT is entered once.
- HALT: halted=1, cpu_stall=1, mem_en=0.
- HALT -> IDLE on soft_clr. This clears load_count and the stall counter, but not ld_err or fetch_err.
- soft_clr in any other state is ignored.
- Reset asserted mid-LOAD: the partial image stays in memory, and the FSM restarts from IDLE.

Decomposition:
- Package imem_ctrl_pkg holds:
  - the state_t enum (IDLE/LOAD/RUN/HALT, 2-bit);
  - the default ADDR_W and HALT_CYC constants;
  - the fetch-alignment mask constant.
- One sub-module, pc_loop_detect, contains the PC history register, the equal-PC counter and the halt_hit output, parameterised by HALT_CYC.

Test Plan:
1. Reset, then stream 4 words at addr 0..3 (0x00000013 ×3, then 0x0000006F with ld_last) → mem_we high on those 4 accepts; load_count=4; state goes IDLE→LOAD→RUN; cpu_stall falls the cycle after the last accept.
2. Loader drops ld_valid for 5 cycles mid-LOAD → ld_ready stays 1, no writes, state stays LOAD, load_count unchanged; the stream then resumes and completes.
3. Word at ld_addr=DEPTH+2 → no mem_we, ld_err=1, load_count unchanged; later valid words still written; ld_err persists into RUN.
4. RUN with pc_current_s1 held at 0x00000690 for HALT_CYC cycles (after 0x00000670) → halted=1 exactly HALT_CYC cycles after the PC first repeats; cpu_stall=1; mem_en=0. A 0→4→0 alternation for 50 cycles → stays in RUN.
5. RUN with pc_current_s1=0x00000102 → fetch_err=1 and HALT next edge. Then soft_clr pulse → IDLE, load_count=0, fetch_err still 1.
6. Assert rst_n low mid-LOAD after 2 words → all outputs at reset values immediately (async). After release, state=IDLE, ld_ready=1, load_count=0.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_HALT_CYC = 8;

    // Any set bit here in a fetch PC means the fetch is not word aligned.
    localparam logic [1:0] FETCH_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_loop_detect.sv
// Detects a CPU parked on a single PC: counts consecutive cycles with an unchanged
// fetch PC and flags halt_hit_o on the cycle the run length reaches HALT_CYC.
module pc_loop_detect
    import imem_ctrl_pkg::*;
#(
    parameter int HALT_CYC = DEF_HALT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] pc_i,
    output logic        halt_hit_o
);

    localparam logic [7:0] LIMIT = 8'(HALT_CYC - 1);

    logic [31:0] pc_hist_q;
    logic [7:0]  same_cnt_q;
    logic [7:0]  same_cnt_d;
    logic        pc_same;

    assign pc_same = (pc_i == pc_hist_q);

    always_comb begin
        same_cnt_d = '0;
        if (en_i && !clr_i && pc_same && same_cnt_q != 8'hFF) begin
            same_cnt_d = same_cnt_q + 8'd1;
        end
    end

    assign halt_hit_o = en_i & pc_same & (same_cnt_q == LIMIT);

    // History tracks the PC even while stalled so the first RUN cycle compares
    // against the PC the core was frozen on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_hist_q  <= '0;
            same_cnt_q <= '0;
        end else begin
            pc_hist_q  <= pc_i;
            same_cnt_q <= same_cnt_d;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory port owner: loads a program from a valid/ready loader, hands
// the port to the fetch stage, and parks the core in HALT on end-of-test.
module imem_boot_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int HALT_CYC = DEF_HALT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              soft_clr,
    input  logic [31:0]       pc_current_s1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              halted,
    output logic              ld_err,
    output logic              fetch_err,
    output logic [ADDR_W:0]   load_count,
    output logic [1:0]        state
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [31:0]     DEPTH_A   = 32'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    logic              ld_err_q;
    logic              fetch_err_q;
    logic [ADDR_W:0]   load_count_q;

    logic accept;
    logic in_range;
    logic in_run;
    logic misaligned;
    logic halt_hit;

    assign ld_ready   = (state_q == IDLE) || (state_q == LOAD);
    assign accept     = ld_valid & ld_ready;
    assign in_range   = (ld_addr < DEPTH_A);
    assign in_run     = (state_q == RUN);
    assign misaligned = in_run && ((pc_current_s1[1:0] & FETCH_ALIGN_MASK) != 2'b00);

    pc_loop_detect #(
        .HALT_CYC (HALT_CYC)
    ) u_loop_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (in_run),
        .clr_i      (soft_clr && state_q == HALT),
        .pc_i       (pc_current_s1),
        .halt_hit_o (halt_hit)
    );

    // Port mux: loader writes while loading, fetch reads in RUN, idle in HALT.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ld_addr[ADDR_W-1:0];
        mem_wdata = ld_data;
        if (in_run) begin
            mem_en   = 1'b1;
            mem_addr = pc_current_s1[ADDR_W+1:2];
        end else if (accept && in_range) begin
            mem_we = 1'b1;
            mem_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ld_err_q     <= 1'b0;
            fetch_err_q  <= 1'b0;
            load_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) state_q <= ld_last ? RUN : LOAD;
                LOAD: if (accept && ld_last) state_q <= RUN;
                RUN:  if (misaligned || halt_hit) state_q <= HALT;
                HALT: begin
                    if (soft_clr) begin
                        state_q      <= IDLE;
                        load_count_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept && !in_range) ld_err_q <= 1'b1;
            if (accept && in_range && load_count_q != DEPTH_CNT) begin
                load_count_q <= load_count_q + 1'b1;
            end
            if (misaligned) fetch_err_q <= 1'b1;
        end
    end

    assign cpu_stall  = (state_q != RUN);
    assign halted     = (state_q == HALT);
    assign ld_err     = ld_err_q;
    assign fetch_err  = fetch_err_q;
    assign load_count = load_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scenario bench for imem_boot_ctrl: expected memory writes are queued as words are
// driven and matched by a monitor whenever the DUT raises mem_we.
module tb_imem_boot_ctrl;

    localparam int ADDR_W   = 10;
    localparam int HALT_CYC = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [31:0]       ld_addr = '0;
    logic [31:0]       ld_data = '0;
    logic              ld_last = 1'b0;
    logic              soft_clr = 1'b0;
    logic [31:0]       pc_current_s1 = '0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_stall;
    logic              halted;
    logic              ld_err;
    logic              fetch_err;
    logic [ADDR_W:0]   load_count;
    logic [1:0]        state;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [ADDR_W-1:0] mon_addr;
    logic [31:0]       mon_data;

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .HALT_CYC(HALT_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_last       (ld_last),
        .soft_clr      (soft_clr),
        .pc_current_s1 (pc_current_s1),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_stall     (cpu_stall),
        .halted        (halted),
        .ld_err        (ld_err),
        .fetch_err     (fetch_err),
        .load_count    (load_count),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Write monitor: every mem_we must match the oldest queued in-range word.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_wdata);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                if (mem_addr !== mon_addr || mem_wdata !== mon_data) begin
                    errors++;
                    $display("FAIL write_match got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_wdata, mon_addr, mon_data);
                end else begin
                    $display("write addr=%h data=%h ok", mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [31:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        if (a < 32'(DEPTH)) begin
            exp_addr_q.push_back(a[ADDR_W-1:0]);
            exp_data_q.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (state !== 2'd0 || cpu_stall !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl state=%0d stall=%b halted=%b expected 0/1/0", state, cpu_stall, halted);
        end
        checks++;
        if (ld_err !== 1'b0 || fetch_err !== 1'b0 || load_count !== '0 || ld_ready !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags ld_err=%b fetch_err=%b count=%0d ready=%b en=%b expected 0/0/0/1/0",
                     ld_err, fetch_err, load_count, ld_ready, mem_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic_load();
        pc_current_s1 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            drive_word(32'(i), (i == 3) ? 32'h0000006F : 32'h00000013, i == 3);
            @(negedge clk);
            checks++;
            if (ld_ready !== 1'b1 || cpu_stall !== 1'b1 || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL load_word%0d ready=%b stall=%b state=%0d expected 1/1/%0d",
                         i, ld_ready, cpu_stall, state, (i == 0) ? 0 : 1);
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if (state !== 2'd2 || cpu_stall !== 1'b0 || load_count !== 11'd4) begin
            errors++;
            $display("FAIL load_done state=%0d stall=%b count=%0d expected 2/0/4", state, cpu_stall, load_count);
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL load_writes pending=%0d expected 0", exp_addr_q.size());
        end
        $display("test_basic_load done count=%0d", load_count);
    endtask

    task automatic test_loop_halt();
        int n;
        pc_current_s1 = 32'h00000670;
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL soft_clr_in_run state=%0d expected 2", state);
        end
        pc_current_s1 = 32'h00000690;
        tick();
        n = 0;
        while (halted !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != HALT_CYC) begin
            errors++;
            $display("FAIL loop_halt_latency cycles=%0d expected %0d", n, HALT_CYC);
        end
        @(negedge clk);
        checks++;
        if (state !== 2'd3 || cpu_stall !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_outputs state=%0d stall=%b en=%b expected 3/1/0", state, cpu_stall, mem_en);
        end
        tick();
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        checks++;
        if (state !== 2'd0 || load_count !== '0) begin
            errors++;
            $display("FAIL loop_soft_clr state=%0d count=%0d expected 0/0", state, load_count);
        end
        $display("test_loop_halt done cycles=%0d", n);
    endtask

    task automatic test_stall_resume();
        drive_word(32'h10, 32'hA0, 1'b0);
        tick();
        drive_word(32'h11, 32'hA1, 1'b0);
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ld_ready !== 1'b1 || state !== 2'd1 || load_count !== 11'd2 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL gap_cycle%0d ready=%b state=%0d count=%0d we=%b expected 1/1/2/0",
                         i, ld_ready, state, load_count, mem_we);
            end
            tick();
        end
        drive_word(32'h12, 32'hA2, 1'b0);
        tick();
        drive_word(32'h13, 32'hA3, 1'b1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if (state !== 2'd2 || load_count !== 11'd4 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL resume_done state=%0d count=%0d pending=%0d expected 2/4/0",
                     state, load_count, exp_addr_q.size());
        end
        $display("test_stall_resume done count=%0d", load_count);
    endtask

    task automatic test_alt_no_halt();
        for (int i = 0; i < 50; i++) begin
            pc_current_s1 = (i % 2 == 0) ? 32'h0 : 32'h4;
            tick();
        end
        checks++;
        if (state !== 2'd2 || halted !== 1'b0) begin
            errors++;
            $display("FAIL alt_loop state=%0d halted=%b expected 2/0", state, halted);
        end
        pc_current_s1 = 32'h00001004;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h001) begin
            errors++;
            $display("FAIL fetch_wrap en=%b we=%b addr=%h expected 1/0/001", mem_en, mem_we, mem_addr);
        end
        tick();
        pc_current_s1 = 32'h00000690;
        @(negedge clk);
        checks++;
        if (mem_addr !== 10'h1A4) begin
            errors++;
            $display("FAIL fetch_addr addr=%h expected 1a4", mem_addr);
        end
        tick();
        $display("test_alt_no_halt done state=%0d", state);
    endtask

    task automatic test_misaligned();
        pc_current_s1 = 32'h00000102;
        @(negedge clk);
        checks++;
        if (state !== 2'd2 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pre state=%0d fetch_err=%b expected 2/0", state, fetch_err);
        end
        tick();
        checks++;
        if (state !== 2'd3 || halted !== 1'b1 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_halt state=%0d halted=%b fetch_err=%b expected 3/1/1", state, halted, fetch_err);
        end
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        checks++;
        if (state !== 2'd0 || load_count !== '0 || fetch_err !== 1'b1 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL misalign_clr state=%0d count=%0d fetch_err=%b stall=%b expected 0/0/1/1",
                     state, load_count, fetch_err, cpu_stall);
        end
        pc_current_s1 = 32'h0;
        $display("test_misaligned done fetch_err=%b", fetch_err);
    endtask

    task automatic test_out_of_range();
        drive_word(32'h20, 32'hB0, 1'b0);
        @(negedge clk);
        checks++;
        if (ld_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_pre ld_err=%b expected 0", ld_err);
        end
        tick();
        drive_word(32'(DEPTH + 2), 32'hDEAD, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL oor_write we=%b ready=%b expected 0/1", mem_we, ld_ready);
        end
        tick();
        checks++;
        if (ld_err !== 1'b1 || load_count !== 11'd1) begin
            errors++;
            $display("FAIL oor_flag ld_err=%b count=%0d expected 1/1", ld_err, load_count);
        end
        drive_word(32'h21, 32'hB1, 1'b1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if (state !== 2'd2 || ld_err !== 1'b1 || load_count !== 11'd2 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL oor_run state=%0d ld_err=%b count=%0d pending=%0d expected 2/1/2/0",
                     state, ld_err, load_count, exp_addr_q.size());
        end
        $display("test_out_of_range done ld_err=%b", ld_err);
    endtask

    task automatic test_mid_reset();
        pc_current_s1 = 32'h2;
        tick();
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        pc_current_s1 = 32'h0;
        drive_word(32'h30, 32'hC0, 1'b0);
        tick();
        drive_word(32'h31, 32'hC1, 1'b0);
        tick();
        ld_valid = 1'b0;
        checks++;
        if (state !== 2'd1 || load_count !== 11'd2 || ld_err !== 1'b1 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre state=%0d count=%0d ld_err=%b fetch_err=%b expected 1/2/1/1",
                     state, load_count, ld_err, fetch_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || cpu_stall !== 1'b1 || halted !== 1'b0 || ld_err !== 1'b0 ||
            fetch_err !== 1'b0 || load_count !== '0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async state=%0d stall=%b halted=%b ld_err=%b fetch_err=%b count=%0d en=%b expected 0/1/0/0/0/0/0",
                     state, cpu_stall, halted, ld_err, fetch_err, load_count, mem_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (state !== 2'd0 || ld_ready !== 1'b1 || load_count !== '0) begin
            errors++;
            $display("FAIL midrst_after state=%0d ready=%b count=%0d expected 0/1/0", state, ld_ready, load_count);
        end
        $display("test_mid_reset done state=%0d", state);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_loop_halt();
        test_stall_resume();
        test_alt_no_halt();
        test_misaligned();
        test_out_of_range();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
